// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and opcode constants for the two-requester RAM command arbiter.
// A RAM command word is {opcode[1:0], address_or_data[7:0]}.
package spi_ram_arb_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RSP} state_e;
  typedef enum logic {KIND_WR, KIND_RD} kind_e;

  // True when op continues a pair of the given kind (its address or its data).
  function automatic logic cmd_legal(kind_e kind, logic [1:0] op);
    if (kind == KIND_WR) return (op == CMD_WR_ADDR) || (op == CMD_WR_DATA);
    return (op == CMD_RD_ADDR) || (op == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for spi_ram_arbiter.
// The arbiter takes the slave modport; the surrounding logic drives the master side.
interface spi_ram_arbiter_if;
  logic       req0_valid;
  logic [9:0] req0_din;
  logic       req0_ready;
  logic       req0_rsp_valid;
  logic [7:0] req0_rsp_data;
  logic       req1_valid;
  logic [9:0] req1_din;
  logic       req1_ready;
  logic       req1_rsp_valid;
  logic [7:0] req1_rsp_data;
  logic       ram_rx_valid;
  logic [9:0] ram_din;
  logic       ram_tx_valid;
  logic [7:0] ram_dout;
  logic       owner;
  logic       busy;
  logic       err_proto;
  logic       err_timeout;

  modport slave (
    input  req0_valid, req0_din, req1_valid, req1_din, ram_tx_valid, ram_dout,
    output req0_ready, req0_rsp_valid, req0_rsp_data,
    output req1_ready, req1_rsp_valid, req1_rsp_data,
    output ram_rx_valid, ram_din, owner, busy, err_proto, err_timeout
  );

  modport master (
    output req0_valid, req0_din, req1_valid, req1_din, ram_tx_valid, ram_dout,
    input  req0_ready, req0_rsp_valid, req0_rsp_data,
    input  req1_ready, req1_rsp_valid, req1_rsp_data,
    input  ram_rx_valid, ram_din, owner, busy, err_proto, err_timeout
  );
endinterface

// File: rtl/spi_ram_rr2.sv
// Two-way round-robin picker: ptr names the favoured requester on a tie.
module spi_ram_rr2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~ptr | ~valid[1]);
    grant[1] = valid[1] & (ptr | ~valid[0]);
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter and address/data pair sequencer in front of the single-port RAM,
// with read-data routing back to the owner and timeout release of abandoned pairs.
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int unsigned LOCK_TO = 16
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(LOCK_TO + 1);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ram_rx_valid_q;
  logic [9:0]      ram_din_q, ram_din_d;

  logic [1:0] valid, grant, ready;
  logic       act, fwd, err_proto, err_timeout, cnt_full;
  logic [9:0] act_din;
  logic [1:0] op;

  assign valid    = {bus.req1_valid, bus.req0_valid};
  assign cnt_full = (cnt_q == CntW'(LOCK_TO));

  spi_ram_rr2 u_rr2 (
    .valid (valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      kind_q         <= KIND_WR;
      owner_q        <= 1'b0;
      ptr_q          <= 1'b0;
      cnt_q          <= '0;
      ram_rx_valid_q <= 1'b0;
      ram_din_q      <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      ram_rx_valid_q <= fwd;
      ram_din_q      <= ram_din_d;
    end
  end

  // Handshake decode: who is served this cycle and what happens to the word.
  always_comb begin
    ready       = '0;
    fwd         = 1'b0;
    err_proto   = 1'b0;
    err_timeout = 1'b0;
    act         = (state_q == IDLE) ? grant[1] : owner_q;
    act_din     = act ? bus.req1_din : bus.req0_din;
    op          = act_din[9:8];
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          ready[act] = 1'b1;
          fwd        = (op == CMD_WR_ADDR) || (op == CMD_RD_ADDR);
          err_proto  = ~fwd;
        end
      end
      LOCKED: begin
        if (valid[act]) begin
          ready[act] = 1'b1;
          fwd        = cmd_legal(kind_q, op);
          err_proto  = ~fwd;
        end else begin
          err_timeout = cnt_full;
        end
      end
      WAIT_RSP: err_timeout = cnt_full & ~bus.ram_tx_valid;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ram_din_d = fwd ? act_din : ram_din_q;
    unique case (state_q)
      IDLE: begin
        if (fwd) begin
          state_d = LOCKED;
          owner_d = act;
          kind_d  = (op == CMD_RD_ADDR) ? KIND_RD : KIND_WR;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (fwd) begin
          cnt_d = '0;
          if (op == CMD_WR_DATA) begin
            state_d = IDLE;
            ptr_d   = ~owner_q;
          end else if (op == CMD_RD_DATA) begin
            state_d = WAIT_RSP;
          end
        end else if (err_timeout) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
          cnt_d   = '0;
        end else if (~|ready && !cnt_full) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RSP: begin
        if (bus.ram_tx_valid || err_timeout) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
          cnt_d   = '0;
        end else if (!cnt_full) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready     = ready[0];
  assign bus.req1_ready     = ready[1];
  assign bus.req0_rsp_valid = bus.ram_tx_valid & ~owner_q & (state_q == WAIT_RSP);
  assign bus.req1_rsp_valid = bus.ram_tx_valid & owner_q & (state_q == WAIT_RSP);
  assign bus.req0_rsp_data  = bus.ram_dout;
  assign bus.req1_rsp_data  = bus.ram_dout;
  assign bus.ram_rx_valid   = ram_rx_valid_q;
  assign bus.ram_din        = ram_din_q;
  assign bus.owner          = owner_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.err_proto      = err_proto;
  assign bus.err_timeout    = err_timeout;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scenario bench for spi_ram_arbiter with a behavioural RAM and command/response scoreboards.
module tb_spi_ram_arbiter;

  localparam int unsigned LockTo = 16;

  typedef struct {
    bit       who;
    bit [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   to_cnt = 0;
  int   to_cyc = -1;

  logic [9:0] exp_cmd[$];
  rsp_t       exp_rsp[$];

  logic [7:0] mem [256];
  logic [7:0] addr_r;

  spi_ram_arbiter_if bus ();

  spi_ram_arbiter #(
    .LOCK_TO (LockTo)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: answers a read-data command one cycle after receiving it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_tx_valid <= 1'b0;
      bus.ram_dout     <= 8'h00;
      addr_r           <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      bus.ram_tx_valid <= 1'b0;
      if (bus.ram_rx_valid) begin
        case (bus.ram_din[9:8])
          2'b00, 2'b10: addr_r <= bus.ram_din[7:0];
          2'b01:        mem[addr_r] <= bus.ram_din[7:0];
          default: begin
            bus.ram_tx_valid <= 1'b1;
            bus.ram_dout     <= mem[addr_r];
          end
        endcase
      end
    end
  end

  // Scoreboard side: every RAM command and every response must have been predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_timeout === 1'b1) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (bus.ram_rx_valid === 1'b1) begin
        n_cmp++;
        if (exp_cmd.size() == 0) begin
          n_bad++;
          $display("FAIL ram_cmd unexpected got %h want none", bus.ram_din);
        end else begin
          logic [9:0] e;
          e = exp_cmd.pop_front();
          if (bus.ram_din !== e) begin
            n_bad++;
            $display("FAIL ram_cmd got %h want %h", bus.ram_din, e);
          end
        end
      end
      if ((bus.req0_rsp_valid | bus.req1_rsp_valid) === 1'b1) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_bad++;
          $display("FAIL rsp unexpected got v0=%b v1=%b want none",
                   bus.req0_rsp_valid, bus.req1_rsp_valid);
        end else begin
          rsp_t e;
          logic [7:0] d;
          e = exp_rsp.pop_front();
          d = e.who ? bus.req1_rsp_data : bus.req0_rsp_data;
          if ({bus.req1_rsp_valid, bus.req0_rsp_valid} !== (e.who ? 2'b10 : 2'b01) ||
              d !== e.data) begin
            n_bad++;
            $display("FAIL rsp got v=%b%b d=%h want who=%0d d=%h", bus.req1_rsp_valid,
                     bus.req0_rsp_valid, d, e.who, e.data);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Offer one command word and wait (bounded) for the handshake.
  task automatic put(input bit who, input logic [9:0] din, input bit expect_fwd,
                     output int hs, output bit ep);
    hs = -1;
    ep = 1'b0;
    @(negedge clk);
    if (who) begin
      bus.req1_valid = 1'b1;
      bus.req1_din   = din;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_din   = din;
    end
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((who ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        hs = cyc;
        ep = bus.err_proto;
        if (expect_fwd) exp_cmd.push_back(din);
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake req%0d got none want ready for %h", who, din);
    end else begin
      @(posedge clk);
      #1;
    end
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_din   = '0;
    bus.req1_din   = '0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if ({bus.req0_rsp_valid, bus.req1_rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_rsp_valid got %b%b want 00", bus.req0_rsp_valid, bus.req1_rsp_valid);
    end
    n_cmp++;
    if (bus.ram_rx_valid !== 1'b0 || bus.ram_din !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_ram got v=%b d=%h want v=0 d=000", bus.ram_rx_valid, bus.ram_din);
    end
    n_cmp++;
    if ({bus.owner, bus.busy, bus.err_proto, bus.err_timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_status got %b%b%b%b want 0000", bus.owner, bus.busy,
               bus.err_proto, bus.err_timeout);
    end
    n_cmp++;
    if (bus.req0_rsp_data !== 8'h00 || bus.req1_rsp_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_rsp_data got %h %h want 00 00", bus.req0_rsp_data, bus.req1_rsp_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int hs;
    bit ep;
    put(0, 10'h012, 1'b1, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (bus.ram_rx_valid !== 1'b1 || bus.busy !== 1'b1 || bus.owner !== 1'b0 || ep !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_addr got rx=%b busy=%b own=%b ep=%b want 1 1 0 0", bus.ram_rx_valid,
               bus.busy, bus.owner, ep);
    end
    put(0, 10'h1A5, 1'b1, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (bus.ram_rx_valid !== 1'b1 || bus.busy !== 1'b0 || ep !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_data got rx=%b busy=%b ep=%b want 1 0 0", bus.ram_rx_valid, bus.busy, ep);
    end
  endtask

  task automatic test_read();
    int hs;
    bit ep;
    rsp_t r;
    put(1, 10'h212, 1'b1, hs, ep);
    r.who  = 1'b1;
    r.data = 8'hA5;
    exp_rsp.push_back(r);
    put(1, 10'h300, 1'b1, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (bus.req1_rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_early got rsp=%b busy=%b want 0 1", bus.req1_rsp_valid, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.req1_rsp_valid !== 1'b1 || bus.req1_rsp_data !== 8'hA5 ||
        bus.req0_rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp got v1=%b d=%h v0=%b want 1 a5 0", bus.req1_rsp_valid,
               bus.req1_rsp_data, bus.req0_rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_release got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_contention();
    int h0a, h0b, h1a, h1b;
    bit e0, e1;
    do_reset();
    fork
      begin
        put(0, 10'h034, 1'b1, h0a, e0);
        put(0, 10'h156, 1'b1, h0b, e0);
      end
      begin
        put(1, 10'h078, 1'b1, h1a, e1);
        put(1, 10'h19A, 1'b1, h1b, e1);
      end
    join
    n_cmp++;
    if (h0b !== h0a + 1 || h1a !== h0b + 1 || h1b !== h1a + 1) begin
      n_bad++;
      $display("FAIL contention got %0d %0d %0d %0d want consecutive from req0", h0a, h0b,
               h1a, h1b);
    end
  endtask

  task automatic test_timeout();
    int h0, h1, h2, to_before;
    bit e0, e1;
    to_before = to_cnt;
    fork
      put(0, 10'h205, 1'b1, h0, e0);
      begin
        repeat (2) @(negedge clk);
        put(1, 10'h040, 1'b1, h1, e1);
        put(1, 10'h141, 1'b1, h2, e1);
      end
    join
    n_cmp++;
    if (to_cyc !== h0 + int'(LockTo) + 1 || to_cnt - to_before !== 1) begin
      n_bad++;
      $display("FAIL timeout got cyc=%0d pulses=%0d want cyc=%0d pulses=1", to_cyc,
               to_cnt - to_before, h0 + int'(LockTo) + 1);
    end
    n_cmp++;
    if (h1 !== to_cyc + 1) begin
      n_bad++;
      $display("FAIL timeout_regrant got %0d want %0d", h1, to_cyc + 1);
    end
  endtask

  task automatic test_proto();
    int hs;
    bit ep;
    put(0, 10'h1FF, 1'b0, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (hs < 0 || ep !== 1'b1 || bus.ram_rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL proto_idle got hs=%0d ep=%b rx=%b busy=%b want ep=1 rx=0 busy=0", hs, ep,
               bus.ram_rx_valid, bus.busy);
    end
    put(0, 10'h001, 1'b1, hs, ep);
    put(0, 10'h300, 1'b0, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (ep !== 1'b1 || bus.busy !== 1'b1 || bus.ram_rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL proto_locked got ep=%b busy=%b rx=%b want 1 1 0", ep, bus.busy,
               bus.ram_rx_valid);
    end
    put(0, 10'h1CC, 1'b1, hs, ep);
    @(negedge clk);
    n_cmp++;
    if (ep !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL proto_recover got ep=%b busy=%b want 0 0", ep, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    bit ep;
    rsp_t r;
    put(1, 10'h212, 1'b1, hs, ep);
    put(1, 10'h300, 1'b1, hs, ep);
    #1 rst_n = 1'b0;
    exp_cmd.delete();
    exp_rsp.delete();
    #1;
    n_cmp++;
    if ({bus.busy, bus.owner, bus.ram_rx_valid, bus.req0_rsp_valid, bus.req1_rsp_valid}
        !== 5'b00000 || bus.ram_din !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_mid got busy=%b own=%b rx=%b rsp=%b%b din=%h want all 0", bus.busy,
               bus.owner, bus.ram_rx_valid, bus.req0_rsp_valid, bus.req1_rsp_valid, bus.ram_din);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    put(0, 10'h033, 1'b1, hs, ep);
    put(0, 10'h177, 1'b1, hs, ep);
    put(0, 10'h233, 1'b1, hs, ep);
    r.who  = 1'b0;
    r.data = 8'h77;
    exp_rsp.push_back(r);
    put(0, 10'h300, 1'b1, hs, ep);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_after got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_drain();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
      n_bad++;
      $display("FAIL drain got cmd=%0d rsp=%0d pending want 0 0", exp_cmd.size(),
               exp_rsp.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_proto();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-requester arbiter and command sequencer for the single-port RAM. It sits between the SPI slave (requester 0) and a second on-chip command source (requester 1) on one side, and the RAM's 10-bit command port on the other. It grants the RAM round-robin and holds the grant across each address/data command pair. It returns read data to the owner and recovers from abandoned pairs by timeout.

## Interface
- `LOCK_TO`, default 16: idle cycles allowed in LOCKED or WAIT_RSP before forced release; minimum 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `reqN_valid`  in  1  command valid, requester N (N = 0, 1).
- `reqN_din`  in  10  command word: [9:8] opcode, [7:0] address/data.
- `reqN_ready`  out  1  command consumed this cycle.
- `reqN_rsp_valid`  out  1  read data valid for requester N.
- `reqN_rsp_data`  out  8  read data.
- `ram_rx_valid`  out  1  command strobe to RAM (registered).
- `ram_din`  out  10  command word to RAM (registered).
- `ram_tx_valid`  in  1  RAM read-data valid.
- `ram_dout`  in  8  RAM read data.
- `owner`  out  1  current/last granted requester.
- `busy`  out  1  state != IDLE.
- `err_proto`  out  1  one-cycle pulse: illegal command consumed and dropped.
- `err_timeout`  out  1  one-cycle pulse: forced release.

## Operation
- Opcodes: 00 write address, 01 write data, 10 read address, 11 read data.
- IDLE:
  - The round-robin pointer selects among valid requesters. After reset the pointer favours req0; after any release it favours the non-owner.
  - Winner with opcode 00/10: ready=1, forward, set owner, record kind (write/read), go to LOCKED, clear counter.
  - Winner with opcode 01/11: ready=1, not forwarded, err_proto pulse, stay IDLE, pointer unchanged.
  - Loser: ready=0.
- LOCKED:
  - Only the owner may get ready=1; the other requester's ready=0.
  - Same-kind address (00 when kind=write, 10 when kind=read): forward, clear counter.
  - Matching data, write: 01 forwards and goes to IDLE.
  - Matching data, read: 11 forwards and goes to WAIT_RSP.
  - Any other opcode: consumed, dropped, err_proto, stay LOCKED, counter not cleared.
- WAIT_RSP:
  - All ready=0.
  - When ram_tx_valid=1, go to IDLE.
- Response routing (combinational): reqN_rsp_valid = ram_tx_valid & (owner==N) & state==WAIT_RSP. Both rsp_data outputs carry ram_dout.
- Timeout:
  - The counter increments each cycle in LOCKED without an owner handshake, and each cycle in WAIT_RSP.
  - On reaching LOCK_TO: go to IDLE, pulse err_timeout, nothing forwarded, pointer favours the non-owner.
  - Counter width $clog2(LOCK_TO+1); saturating.

## Timing
- A handshake in cycle N drives ram_rx_valid/ram_din in cycle N+1. The RAM asserts ram_tx_valid in N+2, and reqN_rsp_valid appears in N+2.
- A write pair takes at minimum 2 handshake cycles. The next grant is possible in the cycle after the write-data handshake.
- A read pair leaves the RAM free again in the cycle after ram_tx_valid. Minimum 4 cycles from read-address handshake to next grant.
- ram_rx_valid is high for exactly one cycle per forwarded command; dropped commands never reach the RAM.
- Simultaneous valid in IDLE: pointer decides. A timeout and an owner handshake in the same cycle: the handshake wins and the counter clears.
- Reset values (asynchronous, immediate): state IDLE, all ready 0, rsp_valid 0, rsp_data 0, ram_rx_valid 0, ram_din 0, owner 0, busy 0, err pulses 0, counter 0, pointer→req0.
- Reset mid-pair abandons the pair; the RAM is reset by the same rst_n.

## Structure
- Package `spi_ram_arb_pkg`: opcode constants CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA, state enum {IDLE, LOCKED, WAIT_RSP}, kind enum {KIND_WR, KIND_RD}.
- Sub-module `spi_ram_rr2`: two-way round-robin picker (valid[1:0], pointer → grant one-hot). The FSM, forwarding register and timeout counter stay in the top.

## Test plan
- req0: 0x0_12 then 0x1_A5 (write addr 0x12, data 0xA5) → ram_din 0x012 then 0x1A5, one cycle after each handshake; state returns to IDLE; no err.
- req1: 0x2_12 then 0x3_00 → ram_rx_valid twice; with RAM model returning 0xA5, req1_rsp_valid=1 with data 0xA5 in handshake+2; req0_rsp_valid stays 0.
- Both valid in IDLE after reset, each sending a write pair → req0 granted first; req1 ready=0 until req0's 0x1_xx is consumed; then req1 granted.
- req0 sends 0x2_05 then stalls → err_timeout after LOCK_TO=16 idle cycles; pending req1 is granted the following cycle.
- req0 sends 0x1_FF in IDLE → ready=1, err_proto pulse, ram_rx_valid stays 0. req0 0x0_01 then 0x3_00 → err_proto; state stays LOCKED.
- Assert rst_n=0 while in WAIT_RSP → all outputs 0 immediately; after release, a fresh req0 write pair completes normally.
